// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared branch predictor constants and types
// Purpose: branch history table geometry, counter state encoding and the
//          default width of the resolve-stage performance counters.
// Ports:   none (package).
package riscv_defines;

  localparam int TABLE_ENTRIES = 64;
  localparam int INDEX_WIDTH   = $clog2(TABLE_ENTRIES);

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bht_state_t;

  localparam int CNT_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
// Purpose: counts cycles with inc high, sticking at all-ones instead of wrapping.
// Ports:   clk   - clock
//          rst   - asynchronous active-high reset, clears count
//          inc   - increment request for this cycle
//          count - current count, WIDTH bits
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - ID-stage branch resolution and predictor update
// Purpose: carries the fetch-time prediction into ID, resolves conditional
//          branches and jumps there, raises a zero-latency redirect on a wrong
//          prediction and counts resolved control-flow events and mispredicts.
// Ports:   clk, rst                - clock, asynchronous active-high reset
//          pc_f, bht_taken         - fetch PC and its predicted direction
//          fetch_valid             - IF slot holds a real instruction
//          stall_d, flush_d        - hold / squash the ID slot
//          is_branch_d, is_jal_d   - ID instruction class
//          cond_d, target_d        - branch outcome and taken target
//          pc_d, cflow_valid,
//          cflow_taken             - predictor update port (index, strobe, dir)
//          mispredict, redirect_pc - front-end redirect request and target
//          branch_cnt,
//          mispredict_cnt          - saturating performance counters
module branch_resolve_unit
  import riscv_defines::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pc_f,
  input  logic                 bht_taken,
  input  logic                 fetch_valid,
  input  logic                 stall_d,
  input  logic                 flush_d,
  input  logic                 is_branch_d,
  input  logic                 is_jal_d,
  input  logic                 cond_d,
  input  logic [31:0]          target_d,
  output logic [31:0]          pc_d,
  output logic                 cflow_valid,
  output logic                 cflow_taken,
  output logic                 mispredict,
  output logic [31:0]          redirect_pc,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispredict_cnt
);

  logic valid_d;
  logic pred_d;
  logic cflow_legal;

  // IF/ID prediction register. A mispredict squashes the wrong-path fetch that
  // would otherwise be captured on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_d <= 1'b0;
      pc_d    <= '0;
      pred_d  <= 1'b0;
    end else if (flush_d || mispredict) begin
      valid_d <= 1'b0;
    end else if (!stall_d) begin
      valid_d <= fetch_valid;
      pc_d    <= pc_f;
      pred_d  <= bht_taken;
    end
  end

  // Branch and jump together is an illegal decode; exactly one must be set.
  assign cflow_legal = is_branch_d ^ is_jal_d;

  // valid_d is cleared asynchronously, so the strobe and redirect are already
  // quiet while rst is high. Gating on !stall_d yields one update per
  // instruction: only in the cycle it actually leaves ID.
  assign cflow_valid = valid_d & cflow_legal & ~stall_d;
  assign cflow_taken = is_jal_d | (is_branch_d & cond_d);
  assign mispredict  = cflow_valid & (cflow_taken != pred_d);

  // Holding off the taken path during reset leaves pc_d + 4 = 4.
  assign redirect_pc = (cflow_taken && !rst) ? target_d : (pc_d + 32'd4);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cflow_valid),
    .count (branch_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_mispredict_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mispredict),
    .count (mispredict_cnt)
  );

endmodule
